hazard_scoreboard: RTL and testbench

Producer-side hazard tracker for the five-stage pipeline. It mirrors the destination register and remaining result latency (Tnew) of every in-flight instruction in E, M and W. It also tracks HI/LO busy time for multiply/divide. From these it raises the D-stage stall, so that every operand the forwarding muxes select is already valid when it is consumed. It sits beside the D/E pipeline register and drives its freeze and bubble controls.

---
 rtl/hazard_scoreboard_pkg.sv | 34 +++
 rtl/hazard_scoreboard_sb_match.sv | 34 +++
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 tb/tb_hazard_scoreboard.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared pipeline encodings and scoreboard entry type
package hazard_scoreboard_pkg;

  // Tuse: cycles until a source is consumed; 3 marks an unused source
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles from E entry until the result reaches a forwarding point
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  // Multiply/divide start classes (2'b11 is illegal and behaves as none)
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // One in-flight producer as seen by the hazard logic
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic [1:0] tnew;
  } sb_entry_t;

  // Remaining latency after one more stage of travel, floored at zero
  function automatic logic [1:0] tnew_next(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// rtl/hazard_scoreboard_sb_match.sv - stall lookup of one source against E/M/W
module sb_match
  import hazard_scoreboard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  sb_entry_t  ent_e,
  input  sb_entry_t  ent_m,
  input  sb_entry_t  ent_w,
  output logic       stall
);

  logic hit_e;
  logic hit_m;
  logic hit_w;

  // Youngest matching producer decides; older matches are shadowed by it
  always_comb begin
    hit_e = ent_e.valid && (ent_e.dest == src);
    hit_m = ent_m.valid && (ent_m.dest == src);
    hit_w = ent_w.valid && (ent_w.dest == src);
    stall = 1'b0;
    if ((src != 5'd0) && (tuse != TUSE_NONE)) begin
      if (hit_e) begin
        stall = ent_e.tnew > tuse;
      end else if (hit_m) begin
        stall = ent_m.tnew > tuse;
      end else if (hit_w) begin
        stall = ent_w.tnew > tuse;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage stall generator from E/M/W producers and HI/LO busy
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [1:0] TuseRsD,
  input  logic [1:0] TuseRtD,
  input  logic [4:0] WriteRegD,
  input  logic       RegWriteD,
  input  logic [1:0] TnewD,
  input  logic [1:0] mdStartD,
  input  logic       mdUseD,
  output logic       stallD,
  output logic       flushE,
  output logic       mdBusy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  sb_entry_t  e_q, e_d;
  sb_entry_t  m_q, m_d;
  sb_entry_t  w_q, w_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;

  sb_match u_match_rs (
    .src   (rsD),
    .tuse  (TuseRsD),
    .ent_e (e_q),
    .ent_m (m_q),
    .ent_w (w_q),
    .stall (stall_rs)
  );

  sb_match u_match_rt (
    .src   (rtD),
    .tuse  (TuseRtD),
    .ent_e (e_q),
    .ent_m (m_q),
    .ent_w (w_q),
    .stall (stall_rt)
  );

  // Stall outputs are purely combinational so reset drops them immediately
  always_comb begin
    mdBusy   = (md_cnt_q != 4'd0);
    stall_md = mdUseD && mdBusy;
    stallD   = stall_rs || stall_rt || stall_md;
    flushE   = stallD;
  end

  // Next shadow entries: D enters E (bubble on stall), M and W always advance
  always_comb begin
    e_d.valid = RegWriteD && !stallD && (WriteRegD != 5'd0);
    e_d.dest  = WriteRegD;
    e_d.tnew  = TnewD;
    m_d       = e_q;
    m_d.tnew  = tnew_next(e_q.tnew);
    w_d       = m_q;
    w_d.tnew  = 2'd0;
  end

  // HI/LO busy counter: reload when a mult/div leaves D, otherwise count down to 0
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (!stallD && (mdStartD == MD_MULT)) begin
      md_cnt_d = MULT_LOAD;
    end else if (!stallD && (mdStartD == MD_DIV)) begin
      md_cnt_d = DIV_LOAD;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      md_cnt_q <= 4'd0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rsD, rtD, WriteRegD;
  logic [1:0] TuseRsD, TuseRtD, TnewD, mdStartD;
  logic       RegWriteD, mdUseD;
  logic       stallD, flushE, mdBusy;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .rsD       (rsD),
    .rtD       (rtD),
    .TuseRsD   (TuseRsD),
    .TuseRtD   (TuseRtD),
    .WriteRegD (WriteRegD),
    .RegWriteD (RegWriteD),
    .TnewD     (TnewD),
    .mdStartD  (mdStartD),
    .mdUseD    (mdUseD),
    .stallD    (stallD),
    .flushE    (flushE),
    .mdBusy    (mdBusy)
  );

  typedef struct {
    logic [4:0] rs, rt, wr;
    logic [1:0] trs, trt, tnew, mds;
    logic       regw, mdu;
  } instr_t;

  typedef struct {
    logic stall;
    logic busy;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [4:0] dest;
    int         tnew;
  } prod_t;

  exp_t   exp_q[$];
  prod_t  prod_q[$];
  int     md_cyc = -100;
  int     md_len = 0;
  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;
  instr_t prev;
  logic   prev_stall = 1'b0;
  bit     prev_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: a producer issued at cycle c with latency T has max(T-(age-1),0)
  // cycles left when seen at age = now-c (1..3); older producers have retired.
  function automatic logic src_stall(input logic [4:0] s, input logic [1:0] t);
    if (s == 5'd0 || t == 2'd3) return 1'b0;
    for (int i = prod_q.size() - 1; i >= 0; i--) begin
      int age;
      int rem;
      age = cyc - prod_q[i].cyc;
      if (age >= 1 && age <= 3 && prod_q[i].dest == s) begin
        rem = prod_q[i].tnew - (age - 1);
        if (rem < 0) rem = 0;
        return rem > int'(t);
      end
    end
    return 1'b0;
  endfunction

  function automatic logic md_busy_now();
    return (cyc - md_cyc) >= 1 && (cyc - md_cyc) <= md_len;
  endfunction

  function automatic instr_t mk(input logic [4:0] rs, input logic [1:0] trs,
                                input logic [4:0] rt, input logic [1:0] trt,
                                input logic [4:0] wr, input logic regw,
                                input logic [1:0] tnew, input logic [1:0] mds,
                                input logic mdu);
    instr_t i;
    i.rs = rs; i.trs = trs; i.rt = rt; i.trt = trt;
    i.wr = wr; i.regw = regw; i.tnew = tnew; i.mds = mds; i.mdu = mdu;
    return i;
  endfunction

  task automatic model_reset();
    prod_q.delete();
    md_len  = 0;
    md_cyc  = -100;
    prev_ok = 1'b0;
  endtask

  // One D-stage cycle: retire last instruction into the model, present the next
  task automatic step(input instr_t i, output logic dstall);
    exp_t e;
    @(posedge clk);
    if (prev_ok && rst_n && !prev_stall) begin
      if (prev.regw && prev.wr != 5'd0) prod_q.push_back('{cyc, prev.wr, int'(prev.tnew)});
      if (prev.mds == 2'b01) begin md_cyc = cyc; md_len = MULT_N; end
      else if (prev.mds == 2'b10) begin md_cyc = cyc; md_len = DIV_N; end
    end
    cyc++;
    while (prod_q.size() > 0 && cyc - prod_q[0].cyc > 3) void'(prod_q.pop_front());
    #1;
    rsD = i.rs; rtD = i.rt; TuseRsD = i.trs; TuseRtD = i.trt;
    WriteRegD = i.wr; RegWriteD = i.regw; TnewD = i.tnew;
    mdStartD = i.mds; mdUseD = i.mdu;
    e.busy  = md_busy_now();
    e.stall = src_stall(i.rs, i.trs) | src_stall(i.rt, i.trt) | (i.mdu & e.busy);
    exp_q.push_back(e);
    prev       = i;
    prev_stall = e.stall;
    prev_ok    = 1'b1;
    #1 dstall = stallD;
  endtask

  // Hold an instruction in D until it leaves; DUT stall cycles must equal want
  task automatic issue(input string name, input instr_t i, input int want);
    int   n = 0;
    int   guard = 0;
    logic ds;
    do begin
      step(i, ds);
      if (ds === 1'b1) n++;
      guard++;
    end while (prev_stall && guard < 40);
    check({name, "_bound"}, 32'(prev_stall), 32'd0);
    check(name, n, want);
  endtask

  // Monitor: compare every presented D cycle against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stallD", 32'(stallD), 32'(e.stall));
      check("flushE", 32'(flushE), 32'(e.stall));
      check("mdBusy", 32'(mdBusy), 32'(e.busy));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t lw8, add8, add9, beq9, lw9, lw0, beq0, lw12, use12, add10, lw10, use10;
    instr_t jal10, beq10, lw13, use13, mult, mflo, dv, lw15, beq15, r;
    logic   ds;

    rst_n = 1'b0;
    rsD = '0; rtD = '0; TuseRsD = 2'd3; TuseRtD = 2'd3; WriteRegD = '0;
    RegWriteD = 1'b0; TnewD = '0; mdStartD = '0; mdUseD = 1'b0;
    #12;
    check("reset_stallD", 32'(stallD), 32'd0);
    check("reset_flushE", 32'(flushE), 32'd0);
    check("reset_mdBusy", 32'(mdBusy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    lw8   = mk(0, 3, 0, 3, 8, 1, 2, 0, 0);
    add8  = mk(8, 1, 0, 3, 11, 1, 1, 0, 0);
    add9  = mk(0, 3, 0, 3, 9, 1, 1, 0, 0);
    beq9  = mk(9, 0, 0, 3, 0, 0, 0, 0, 0);
    lw9   = mk(0, 3, 0, 3, 9, 1, 2, 0, 0);
    lw0   = mk(0, 3, 0, 3, 0, 1, 2, 0, 0);
    beq0  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw12  = mk(0, 3, 0, 3, 12, 1, 2, 0, 0);
    use12 = mk(12, 3, 12, 3, 0, 0, 0, 0, 0);
    add10 = mk(0, 3, 0, 3, 10, 1, 1, 0, 0);
    lw10  = mk(0, 3, 0, 3, 10, 1, 2, 0, 0);
    use10 = mk(10, 1, 0, 3, 0, 0, 0, 0, 0);
    jal10 = mk(0, 3, 0, 3, 10, 1, 0, 0, 0);
    beq10 = mk(10, 0, 0, 3, 0, 0, 0, 0, 0);
    lw13  = mk(0, 3, 0, 3, 13, 1, 2, 0, 0);
    use13 = mk(13, 1, 13, 1, 0, 0, 0, 0, 0);
    mult  = mk(0, 3, 0, 3, 0, 0, 0, 1, 1);
    dv    = mk(0, 3, 0, 3, 0, 0, 0, 2, 1);
    mflo  = mk(0, 3, 0, 3, 2, 1, 1, 0, 1);
    lw15  = mk(0, 3, 0, 3, 15, 1, 2, 0, 0);
    beq15 = mk(15, 0, 0, 3, 0, 0, 0, 0, 0);

    issue("lw8", lw8, 0);
    issue("load_use_tuse1", add8, 1);
    issue("add9", add9, 0);
    issue("alu_branch_tuse0", beq9, 1);
    issue("lw9", lw9, 0);
    issue("load_branch_tuse0", beq9, 2);
    issue("lw0", lw0, 0);
    issue("r0_never_stalls", beq0, 0);
    issue("lw12", lw12, 0);
    issue("tuse3_never_stalls", use12, 0);
    issue("add10", add10, 0);
    issue("lw10", lw10, 0);
    issue("younger_load_wins", use10, 1);
    issue("lw10b", lw10, 0);
    issue("jal10", jal10, 0);
    issue("younger_link_shadows", beq10, 0);
    issue("lw13", lw13, 0);
    issue("rs_rt_single_stall", use13, 1);
    issue("mult", mult, 0);
    issue("mflo_after_mult", mflo, MULT_N);
    issue("div", dv, 0);
    issue("mflo_after_div", mflo, DIV_N);
    issue("mult_idle", mult, 0);
    issue("mult_while_busy", mult, MULT_N);
    issue("mflo_after_mult2", mflo, MULT_N);

    issue("div_pre_reset", dv, 0);
    issue("lw15", lw15, 0);
    step(mflo, ds);
    check("mflo_stalled_before_reset", 32'(ds), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_stallD", 32'(stallD), 32'd0);
    check("midreset_flushE", 32'(flushE), 32'd0);
    check("midreset_mdBusy", 32'(mdBusy), 32'd0);
    rst_n = 1'b1;
    issue("entries_clear_after_reset", beq15, 0);
    issue("md_clear_after_reset", mflo, 0);

    r = beq0;
    for (int k = 0; k < 600; k++) begin
      if (!prev_stall || $urandom_range(0, 3) == 0) begin
        r.rs   = 5'($urandom_range(0, 4));
        r.rt   = 5'($urandom_range(0, 4));
        r.trs  = 2'($urandom_range(0, 3));
        r.trt  = 2'($urandom_range(0, 3));
        r.wr   = 5'($urandom_range(0, 4));
        r.regw = 1'($urandom_range(0, 1));
        r.tnew = 2'($urandom_range(0, 2));
        r.mds  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        r.mdu  = (r.mds != 2'd0) || ($urandom_range(0, 5) == 0);
      end
      step(r, ds);
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
